// File: rtl/det_win_if.sv
// det_win_if: qualifier, detector and result-buffer signals of det_window_accumulator.
// The first_idx/first_vld members exist only when DET_FIRST_HIT_EN is defined.
interface det_win_if #(
  parameter int WIN_LEN = 16,
  parameter int CNT_W = 8
);
  localparam int IW = $clog2(WIN_LEN);
  logic en, x_in, det_in, clr, win_ready;
  logic [CNT_W-1:0] ones_cnt, zeros_cnt;
  logic sat, win_valid, overflow;
  logic [IW-1:0] bit_idx;
`ifdef DET_FIRST_HIT_EN
  logic [IW-1:0] first_idx;
  logic first_vld;
`endif
  modport master (
    output en, x_in, det_in, clr, win_ready,
    input ones_cnt, zeros_cnt, sat, win_valid, overflow, bit_idx
`ifdef DET_FIRST_HIT_EN
    , first_idx, first_vld
`endif
  );
  modport slave (
    input en, x_in, det_in, clr, win_ready,
    output ones_cnt, zeros_cnt, sat, win_valid, overflow, bit_idx
`ifdef DET_FIRST_HIT_EN
    , first_idx, first_vld
`endif
  );
endinterface

// File: rtl/det_window_accumulator.sv
// det_window_accumulator: counts 111/000 detector hits per WIN_LEN-bit window into a single-entry valid/ready buffer.
// Optional DET_FIRST_HIT_EN macro adds the buffered index of the earliest hit in each window.
module det_window_accumulator #(
  parameter int WIN_LEN = 16,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  det_win_if.slave bus
);
  localparam int IW = $clog2(WIN_LEN);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [IW-1:0] LAST = IW'(WIN_LEN - 1);
  typedef enum logic {EMPTY, FULL} state_e;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] acc1_q, acc1_d, acc0_q, acc0_d, ones_q, ones_d, zeros_q, zeros_d, fin1, fin0;
  logic accs_q, accs_d, sat_q, sat_d, ovf_q, ovf_d;
  logic qual, hit1, hit0, fins, done, hs, load, wipe;
  always_comb begin
    qual = bus.en && !bus.clr;
    hit1 = qual && bus.det_in && bus.x_in;
    hit0 = qual && bus.det_in && !bus.x_in;
    fin1 = (hit1 && acc1_q != MAX) ? acc1_q + 1'b1 : acc1_q;
    fin0 = (hit0 && acc0_q != MAX) ? acc0_q + 1'b1 : acc0_q;
    fins = accs_q || (hit1 && acc1_q == MAX) || (hit0 && acc0_q == MAX);
    done = qual && idx_q == LAST;
    wipe = bus.clr || done;
    hs = state_q == FULL && bus.win_ready;
    load = done && (state_q == EMPTY || hs);
    idx_d = wipe ? '0 : bus.en ? idx_q + 1'b1 : idx_q;
    acc1_d = wipe ? '0 : fin1;
    acc0_d = wipe ? '0 : fin0;
    accs_d = !wipe && fins;
    ones_d = load ? fin1 : ones_q;
    zeros_d = load ? fin0 : zeros_q;
    sat_d = load ? fins : sat_q;
    ovf_d = !bus.clr && (ovf_q || (done && !load));
    state_d = (load || (state_q == FULL && !hs)) ? FULL : EMPTY;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      idx_q <= '0;
      acc1_q <= '0;
      acc0_q <= '0;
      accs_q <= 1'b0;
      ones_q <= '0;
      zeros_q <= '0;
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      acc1_q <= acc1_d;
      acc0_q <= acc0_d;
      accs_q <= accs_d;
      ones_q <= ones_d;
      zeros_q <= zeros_d;
      sat_q <= sat_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.ones_cnt = ones_q;
  assign bus.zeros_cnt = zeros_q;
  assign bus.sat = sat_q;
  assign bus.win_valid = state_q == FULL;
  assign bus.overflow = ovf_q;
  assign bus.bit_idx = idx_q;
`ifdef DET_FIRST_HIT_EN
  logic [IW-1:0] fidx_acc_q, fidx_acc_d, fidx_q, fidx_d, fin_fidx;
  logic fvld_acc_q, fvld_acc_d, fvld_q, fvld_d, fin_fvld;
  always_comb begin
    fin_fvld = fvld_acc_q || hit1 || hit0;
    fin_fidx = fvld_acc_q ? fidx_acc_q : (hit1 || hit0) ? idx_q : '0;
    fvld_acc_d = !wipe && fin_fvld;
    fidx_acc_d = wipe ? '0 : fin_fidx;
    fvld_d = load ? fin_fvld : fvld_q;
    fidx_d = load ? fin_fidx : fidx_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fidx_acc_q <= '0;
      fvld_acc_q <= 1'b0;
      fidx_q <= '0;
      fvld_q <= 1'b0;
    end else begin
      fidx_acc_q <= fidx_acc_d;
      fvld_acc_q <= fvld_acc_d;
      fidx_q <= fidx_d;
      fvld_q <= fvld_d;
    end
  end
  assign bus.first_idx = fidx_q;
  assign bus.first_vld = fvld_q;
`endif
endmodule

// File: tb/tb_det_window_accumulator.sv
// tb_det_window_accumulator: drives a CNT_W=4 and a CNT_W=2 instance (WIN_LEN=8) with identical stimulus
// and compares both against a count-based reference model, plus vector tables and corner sequences.
module tb_det_window_accumulator;
  localparam int WIN = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, xin = 1'b0, det = 1'b0, clr = 1'b0, rdy = 1'b0;
  int n_cmp = 0, n_err = 0;
  int m_idx, n1, n0, first, b1, b0, bfirst;
  bit m_valid, m_ovf;
  typedef struct {
    bit e, x, d, c, r;
    bit v;
    int ones, zeros;
    bit sat;
  } vec_t;
  vec_t tbl[24];

  always #5 clk = ~clk;

  det_win_if #(.WIN_LEN(WIN), .CNT_W(4)) ifa ();
  det_win_if #(.WIN_LEN(WIN), .CNT_W(2)) ifs ();
  assign ifa.en = en;
  assign ifa.x_in = xin;
  assign ifa.det_in = det;
  assign ifa.clr = clr;
  assign ifa.win_ready = rdy;
  assign ifs.en = en;
  assign ifs.x_in = xin;
  assign ifs.det_in = det;
  assign ifs.clr = clr;
  assign ifs.win_ready = rdy;

  det_window_accumulator #(.WIN_LEN(WIN), .CNT_W(4)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  det_window_accumulator #(.WIN_LEN(WIN), .CNT_W(2)) u_s (.clk(clk), .rst(rst), .bus(ifs));

  function automatic int clamp(int v, int m);
    return v > m ? m : v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; n1 = 0; n0 = 0; first = -1;
    m_valid = 0; m_ovf = 0; b1 = 0; b0 = 0; bfirst = -1;
  endtask

  // Window counts are kept unbounded; saturation is derived when comparing.
  task automatic model_step(input bit e, input bit x, input bit d, input bit c, input bit r);
    bit hs, done;
    hs = m_valid && r;
    done = !c && e && m_idx == WIN - 1;
    if (!c && e && d) begin
      if (x) n1++; else n0++;
      if (first < 0) first = m_idx;
    end
    if (done && (!m_valid || hs)) begin
      b1 = n1; b0 = n0; bfirst = first; m_valid = 1;
    end else if (done) m_ovf = 1;
    else if (hs) m_valid = 0;
    if (c) m_ovf = 0;
    if (c || done) begin
      m_idx = 0; n1 = 0; n0 = 0; first = -1;
    end else if (e) m_idx++;
  endtask

  task automatic check_model();
    chk("a.bit_idx", ifa.bit_idx, m_idx);
    chk("a.win_valid", ifa.win_valid, m_valid);
    chk("a.overflow", ifa.overflow, m_ovf);
    chk("a.ones_cnt", ifa.ones_cnt, clamp(b1, 15));
    chk("a.zeros_cnt", ifa.zeros_cnt, clamp(b0, 15));
    chk("a.sat", ifa.sat, b1 > 15 || b0 > 15);
    chk("s.bit_idx", ifs.bit_idx, m_idx);
    chk("s.win_valid", ifs.win_valid, m_valid);
    chk("s.overflow", ifs.overflow, m_ovf);
    chk("s.ones_cnt", ifs.ones_cnt, clamp(b1, 3));
    chk("s.zeros_cnt", ifs.zeros_cnt, clamp(b0, 3));
    chk("s.sat", ifs.sat, b1 > 3 || b0 > 3);
`ifdef DET_FIRST_HIT_EN
    chk("a.first_vld", ifa.first_vld, bfirst >= 0);
    chk("a.first_idx", ifa.first_idx, bfirst < 0 ? 0 : bfirst);
`endif
  endtask

  task automatic step(input bit e, input bit x, input bit d, input bit c, input bit r);
    en = e; xin = x; det = d; clr = c; rdy = r;
    @(posedge clk);
    model_step(e, x, d, c, r);
    #1 check_model();
  endtask

  initial begin
    logic [7:0] xs, ds;
    xs = 8'b0000_1111;
    ds = 8'b1100_1100;
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, xs[i], ds[i], 1'b0, 1'b1, i == 7, i == 7 ? 2 : 0, i == 7 ? 2 : 0, 1'b0};
    for (int i = 0; i < 16; i++)
      tbl[8 + i] = (i % 2 == 0) ? '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2, 2, 1'b0}
                                : '{1'b1, xs[i / 2], ds[i / 2], 1'b0, 1'b1, i == 15, 2, 2, 1'b0};

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    chk("rst.win_valid", ifa.win_valid, 0);
    chk("rst.ones_cnt", ifa.ones_cnt, 0);
    chk("rst.overflow", ifa.overflow, 0);
    chk("rst.bit_idx", ifa.bit_idx, 0);
    check_model();

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].e, tbl[i].x, tbl[i].d, tbl[i].c, tbl[i].r);
      chk($sformatf("tbl%0d.win_valid", i), ifa.win_valid, tbl[i].v);
      chk($sformatf("tbl%0d.ones_cnt", i), ifa.ones_cnt, tbl[i].ones);
      chk($sformatf("tbl%0d.zeros_cnt", i), ifa.zeros_cnt, tbl[i].zeros);
      chk($sformatf("tbl%0d.sat", i), ifa.sat, tbl[i].sat);
    end

    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 1, i < 3, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0);
    chk("bp.overflow", ifa.overflow, 1);
    chk("bp.win_valid", ifa.win_valid, 1);
    chk("bp.ones_cnt", ifa.ones_cnt, 3);
    chk("bp.zeros_cnt", ifa.zeros_cnt, 0);
    step(1, 1, 1, 1, 0);
    chk("clr.overflow", ifa.overflow, 0);
    chk("clr.win_valid", ifa.win_valid, 1);
    chk("clr.ones_cnt", ifa.ones_cnt, 3);
    chk("clr.bit_idx", ifa.bit_idx, 0);

    for (int i = 0; i < 7; i++) step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 1);
    chk("sim.win_valid", ifa.win_valid, 1);
    chk("sim.zeros_cnt", ifa.zeros_cnt, 8);
    chk("sim.ones_cnt", ifa.ones_cnt, 0);
    chk("sim.overflow", ifa.overflow, 0);
    chk("sim.s_zeros_cnt", ifs.zeros_cnt, 3);

    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0);
    chk("satw.ones_cnt", ifs.ones_cnt, 3);
    chk("satw.zeros_cnt", ifs.zeros_cnt, 0);
    chk("satw.sat", ifs.sat, 1);
    chk("satw.a_ones_cnt", ifa.ones_cnt, 8);
    chk("satw.a_sat", ifa.sat, 0);

    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0);
    rst = 1'b0;
    #1;
    model_reset();
    chk("mrst.ones_cnt", ifa.ones_cnt, 0);
    chk("mrst.sat", ifs.sat, 0);
    chk("mrst.bit_idx", ifa.bit_idx, 0);
    chk("mrst.win_valid", ifa.win_valid, 0);
    check_model();
    #3 rst = 1'b1;
    for (int i = 0; i < 8; i++) step(1, 0, i == 0, 0, 0);
    chk("post.win_valid", ifa.win_valid, 1);
    chk("post.ones_cnt", ifa.ones_cnt, 0);
    chk("post.zeros_cnt", ifa.zeros_cnt, 1);
    chk("post.sat", ifs.sat, 0);

    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 29) == 0, 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/det_window_accumulator.md
Name: det_window_accumulator

Overview:
- Downstream consumer of the serial 111/000 Mealy detector. It takes the detector's combinational detect pulse together with the same-cycle serial bit.
- Each qualified detection is classified by that bit: x=1 is a 111 hit, x=0 is a 000 hit.
- Hits are counted over fixed windows of WIN_LEN qualified bits.
- Each completed window's counts are delivered through a single-entry valid/ready output buffer.

Parameters:
- WIN_LEN, 16, qualified bits per window; must be ≥2.
- CNT_W, 8, width of each hit counter; counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  bit qualifier; each cycle with en=1 is one window bit
- x_in  input  1  serial bit presented to the detector this cycle
- det_in  input  1  detector output, same cycle as x_in
- clr  input  1  synchronous clear of window state and overflow
- ones_cnt  output  CNT_W  111 hits in the delivered window
- zeros_cnt  output  CNT_W  000 hits in the delivered window
- sat  output  1  a counter saturated in the delivered window
- win_valid  output  1  result buffer holds a window
- win_ready  input  1  consumer accepts the result
- overflow  output  1  sticky flag: a window was dropped
- bit_idx  output  clog2(WIN_LEN)  current position within the window

Behaviour:
- Reset (rst=0, asynchronous): the following clear to 0:
  - all outputs
  - the internal accumulators acc1/acc0/acc_sat
  - bit_idx
  - the buffer FSM, which returns to EMPTY
- Accumulate (en=1):
  - det_in=1 and x_in=1: acc1 increments.
  - det_in=1 and x_in=0: acc0 increments.
  - Any increment at max holds the value and sets acc_sat.
  - en=0: nothing changes, and det_in is ignored.
- Window advance: bit_idx increments on each en cycle. The window completes on the en cycle where bit_idx==WIN_LEN-1.
- Completion cycle:
  - The final bit's hit is included in the result.
  - Next cycle: bit_idx=0 and accumulators=0, so back-to-back windows lose no bits.
- Buffer FSM, EMPTY:
  - On completion, load ones_cnt/zeros_cnt/sat from the final accumulated values.
  - Go to FULL; win_valid=1 from the next cycle.
- Buffer FSM, FULL:
  - win_valid=1, and outputs stay stable until the handshake.
  - win_valid&&win_ready with no completion: go to EMPTY; win_valid=0 next cycle; outputs retain their last values.
  - Handshake and completion in the same cycle: load the new result and stay FULL. No overflow.
  - Completion without handshake: the new result is dropped, overflow is set, and the buffered result is preserved.
- clr=1:
  - Next cycle: bit_idx, accumulators and overflow are 0.
  - The bits/hits presented in the clr cycle are discarded.
  - The buffer FSM and its contents are unaffected.
  - clr has priority over en.
- Latency: result visible 1 cycle after the completing en cycle.
- Mid-window async reset: the partial window is discarded and no output pulse occurs.

Optional Feature:
- Macro: DET_FIRST_HIT_EN.
- Defined:
  - Adds output first_idx [clog2(WIN_LEN)-1:0] and output first_vld, both buffered with the window result.
  - first_idx holds the bit_idx of the earliest hit in the window, of either type.
  - first_vld=0 and first_idx=0 when the window had no hits.
  - Both are cleared by reset and clr exactly like the counters.
- Undefined: neither port exists, and there is no related logic.

Test Plan:
- WIN_LEN=8, CNT_W=4, en=1 constant, win_ready=1:
  - Stimulus: x=1,1,1,1,0,0,0,0 with det=0,0,1,1,0,0,1,1.
  - Response: win_valid=1 one cycle after bit 7; ones_cnt=2, zeros_cnt=2, sat=0.
- en gating: the same 8 bits interleaved with en=0 cycles carrying det=1, x=1.
  - Response: identical result, ones_cnt=2, zeros_cnt=2.
- Backpressure: win_ready=0 across two full windows.
  - Response: overflow=1; outputs hold window 1 values.
  - Then pulse clr: overflow=0 the next cycle, and the buffered result is still valid.
- Saturation: CNT_W=2 with 8 bits of det=1, x=1.
  - Response: ones_cnt=3, zeros_cnt=0, sat=1.
- Simultaneous: win_ready=1 exactly on the completing cycle of window 2 while window 1 is FULL.
  - Response: win_valid stays 1, window 2 counts appear, overflow=0.
- Reset mid-window: rst low after bit 4.
  - Response: all outputs 0 immediately.
  - After release, 8 new bits produce a result with no carry-over from the aborted window.
